input_register: RTL and testbench

- User-input counterpart of the 8-bit computer's output register. Captures an 8-bit value from the board switches when the operator presses a load button, then holds it until the CPU reads it onto the bus.
- Provides a one-entry handshake. The CPU sees wait_req while no value is pending and consumes the value with read_ack.
- Sits on the shared bus beside the other registers; bus_out is zero when not driving, so the bus can be an OR-mux.

---
 rtl/input_register.sv | 147 ++++++++++++++
 tb/tb_input_register.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/input_register.sv
// Operator input register: debounced load button captures the switches into a one-entry buffer read by the CPU.
// Latency: load pulse 2 + DEBOUNCE_CYCLES cycles after a clean button rise, data visible the cycle after the pulse; bus_out/wait_req combinational.
// Backpressure: wait_req stalls the CPU while empty; a load while full is dropped (or overwrites) and sets overrun. Option: INPUT_REGISTER_BCD_EN.
module input_register #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter int unsigned OVERWRITE       = 0
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [7:0] sw,
    input  logic       btn_load,
    input  logic       output_en,
    input  logic       read_ack,
    output logic [7:0] bus_out,
    output logic       data_valid,
    output logic       wait_req,
`ifdef INPUT_REGISTER_BCD_EN
    output logic       bcd_error,
`endif
    output logic       overrun
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    logic        sync1_q, sync2_q;
    logic [15:0] deb_cnt_q, deb_cnt_d;
    logic        deb_lvl_q, deb_lvl_d;
    logic        deb_lvl_prev_q;
    logic        load_pulse;

    state_t      state_q, state_d;
    logic [7:0]  data_q, data_d;
    logic        overrun_q, overrun_d;
    logic [7:0]  load_val;
    logic        load_ok;
    logic        load_accept;

    // Debounce: the level only follows sync2 after it has differed for DEBOUNCE_CYCLES straight cycles.
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        deb_lvl_d = deb_lvl_q;
        if (sync2_q == deb_lvl_q) begin
            deb_cnt_d = 16'd0;
        end else if (deb_cnt_q >= DEBOUNCE_CYCLES - 16'd1) begin
            deb_lvl_d = sync2_q;
            deb_cnt_d = 16'd0;
        end else begin
            deb_cnt_d = deb_cnt_q + 16'd1;
        end
    end

    assign load_pulse = deb_lvl_q & ~deb_lvl_prev_q;

`ifdef INPUT_REGISTER_BCD_EN
    logic [3:0] tens;
    logic [3:0] units;
    logic       bcd_error_q, bcd_error_d;

    assign tens     = sw[7:4];
    assign units    = sw[3:0];
    // tens*10 as (tens<<3) + (tens<<1); max 99 fits in 8 bits
    assign load_val = {1'b0, tens, 3'b000} + {3'b000, tens, 1'b0} + {4'b0000, units};
    assign load_ok  = (tens <= 4'd9) && (units <= 4'd9);

    always_comb begin
        bcd_error_d = bcd_error_q | (load_pulse & ~load_ok);
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            bcd_error_q <= 1'b0;
        end else begin
            bcd_error_q <= bcd_error_d;
        end
    end

    assign bcd_error = bcd_error_q;
`else
    assign load_val = sw;
    assign load_ok  = 1'b1;
`endif

    assign load_accept = load_pulse & load_ok;

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        overrun_d = overrun_q;
        case (state_q)
            EMPTY: begin
                if (load_accept) begin
                    data_d  = load_val;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (read_ack) begin
                    // A load landing in the same cycle as the read refills the slot without loss.
                    if (load_accept) begin
                        data_d = load_val;
                    end else begin
                        state_d = EMPTY;
                    end
                end else if (load_accept) begin
                    if (OVERWRITE != 0) begin
                        data_d = load_val;
                    end
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            deb_cnt_q      <= 16'd0;
            deb_lvl_q      <= 1'b0;
            deb_lvl_prev_q <= 1'b0;
            state_q        <= EMPTY;
            data_q         <= 8'h00;
            overrun_q      <= 1'b0;
        end else begin
            sync1_q        <= btn_load;
            sync2_q        <= sync1_q;
            deb_cnt_q      <= deb_cnt_d;
            deb_lvl_q      <= deb_lvl_d;
            deb_lvl_prev_q <= deb_lvl_q;
            state_q        <= state_d;
            data_q         <= data_d;
            overrun_q      <= overrun_d;
        end
    end

    assign data_valid = (state_q == FULL);
    assign bus_out    = (output_en && state_q == FULL) ? data_q : 8'h00;
    assign wait_req   = output_en && (state_q != FULL);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_input_register.sv
// Bench for input_register: two instances (drop vs overwrite on overrun) with DEBOUNCE_CYCLES=4.
module tb_input_register;

    localparam logic [15:0] DEB = 16'd4;

    logic       clk;
    logic       clear;
    logic [7:0] sw;
    logic       btn_load;
    logic       output_en;
    logic       read_ack;

    logic [7:0] bus0, bus1;
    logic       dv0, dv1, wr0, wr1, ov0, ov1;
`ifdef INPUT_REGISTER_BCD_EN
    logic       be0, be1;
`endif

    int checks   = 0;
    int failures = 0;

    input_register #(.DEBOUNCE_CYCLES(DEB), .OVERWRITE(0)) dut0 (
        .clk(clk), .clear(clear), .sw(sw), .btn_load(btn_load),
        .output_en(output_en), .read_ack(read_ack),
        .bus_out(bus0), .data_valid(dv0), .wait_req(wr0),
`ifdef INPUT_REGISTER_BCD_EN
        .bcd_error(be0),
`endif
        .overrun(ov0)
    );

    input_register #(.DEBOUNCE_CYCLES(DEB), .OVERWRITE(1)) dut1 (
        .clk(clk), .clear(clear), .sw(sw), .btn_load(btn_load),
        .output_en(output_en), .read_ack(read_ack),
        .bus_out(bus1), .data_valid(dv1), .wait_req(wr1),
`ifdef INPUT_REGISTER_BCD_EN
        .bcd_error(be1),
`endif
        .overrun(ov1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Value the register should hold for a given switch setting.
    function automatic logic [7:0] exp_val(input logic [7:0] v);
`ifdef INPUT_REGISTER_BCD_EN
        logic [7:0] t;
        logic [7:0] u;
        t = {4'h0, v[7:4]};
        u = {4'h0, v[3:0]};
        return t * 8'd10 + u;
`else
        return v;
`endif
    endfunction

    // Press with optional 1,0 bounce. The pulse is live after 6 posedges from the final
    // rise and captured on the 7th; pre_dv is checked just before that capture edge.
    task automatic press(input string tag, input logic [7:0] v, input bit bounce,
                         input bit ack_same, input logic pre_dv);
        @(negedge clk);
        sw = v;
        if (bounce) begin
            btn_load = 1'b1;
            @(negedge clk);
            btn_load = 1'b0;
            @(negedge clk);
        end
        btn_load = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk({tag, "_pre_dv"}, {7'd0, dv0}, {7'd0, pre_dv});
        read_ack = ack_same;
        @(negedge clk);
        read_ack = 1'b0;
        repeat (4) @(negedge clk);
        btn_load = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        read_ack = 1'b1;
        @(negedge clk);
        read_ack = 1'b0;
    endtask

    typedef struct {
        string      name;
        logic [7:0] sw;
        bit         bounce;
        bit         ack_same;
        bit         ack_after;
        logic       pre_dv;
        logic [7:0] bus;
        logic       ovr;
        logic [7:0] bus_ow;
        logic       ovr_ow;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [7:0] first_sw;
`ifdef INPUT_REGISTER_BCD_EN
        first_sw = 8'h59;
`else
        first_sw = 8'hA5;
`endif
        vecs[0] = '{"bounce_load", first_sw, 1'b1, 1'b0, 1'b1, 1'b0,
                    exp_val(first_sw), 1'b0, exp_val(first_sw), 1'b0};
        vecs[1] = '{"load_11", 8'h11, 1'b0, 1'b0, 1'b0, 1'b0,
                    exp_val(8'h11), 1'b0, exp_val(8'h11), 1'b0};
        vecs[2] = '{"same_cycle_ack", 8'h33, 1'b0, 1'b1, 1'b0, 1'b1,
                    exp_val(8'h33), 1'b0, exp_val(8'h33), 1'b0};
        vecs[3] = '{"overrun", 8'h22, 1'b0, 1'b0, 1'b1, 1'b1,
                    exp_val(8'h33), 1'b1, exp_val(8'h22), 1'b1};
        vecs[4] = '{"sticky_ovr", 8'h44, 1'b0, 1'b0, 1'b0, 1'b0,
                    exp_val(8'h44), 1'b1, exp_val(8'h44), 1'b1};

        clear     = 1'b1;
        sw        = 8'h00;
        btn_load  = 1'b0;
        output_en = 1'b1;
        read_ack  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_bus", bus0, 8'h00);
        chk("rst_dv", {7'd0, dv0}, 8'd0);
        chk("rst_ovr", {7'd0, ov0}, 8'd0);
        chk("rst_wait", {7'd0, wr0}, 8'd1);
        clear = 1'b0;

        // Single-cycle glitch must not load.
        sw       = first_sw;
        btn_load = 1'b1;
        @(negedge clk);
        btn_load = 1'b0;
        repeat (12) @(negedge clk);
        chk("glitch_dv", {7'd0, dv0}, 8'd0);

        // read_ack while empty is ignored.
        ack_pulse();
        @(negedge clk);
        chk("empty_ack_dv", {7'd0, dv0}, 8'd0);
        chk("empty_ack_ovr", {7'd0, ov0}, 8'd0);

        for (int i = 0; i < 5; i++) begin
            press(vecs[i].name, vecs[i].sw, vecs[i].bounce, vecs[i].ack_same, vecs[i].pre_dv);
            chk({vecs[i].name, "_bus"}, bus0, vecs[i].bus);
            chk({vecs[i].name, "_dv"}, {7'd0, dv0}, 8'd1);
            chk({vecs[i].name, "_wait"}, {7'd0, wr0}, 8'd0);
            chk({vecs[i].name, "_ovr"}, {7'd0, ov0}, {7'd0, vecs[i].ovr});
            chk({vecs[i].name, "_bus_ow"}, bus1, vecs[i].bus_ow);
            chk({vecs[i].name, "_ovr_ow"}, {7'd0, ov1}, {7'd0, vecs[i].ovr_ow});
            if (vecs[i].ack_after) begin
                ack_pulse();
                @(negedge clk);
                chk({vecs[i].name, "_ack_dv"}, {7'd0, dv0}, 8'd0);
                chk({vecs[i].name, "_ack_bus"}, bus0, 8'h00);
                chk({vecs[i].name, "_ack_wait"}, {7'd0, wr0}, 8'd1);
            end
        end

        // Clear while FULL with the button held: state lost, reload D+2 cycles after release.
        @(negedge clk);
        sw       = 8'h55;
        btn_load = 1'b1;
        clear    = 1'b1;
        @(negedge clk);
        chk("clr_full_dv", {7'd0, dv0}, 8'd0);
        @(negedge clk);
        clear = 1'b0;
        chk("clr_ovr", {7'd0, ov0}, 8'd0);
        chk("clr_bus", bus0, 8'h00);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("held_pre_dv", {7'd0, dv0}, 8'd0);
        @(negedge clk);
        chk("held_dv", {7'd0, dv0}, 8'd1);
        chk("held_bus", bus0, exp_val(8'h55));
        chk("held_ovr", {7'd0, ov0}, 8'd0);
        btn_load = 1'b0;
        repeat (10) @(negedge clk);
        chk("release_no_load_ovr", {7'd0, ov0}, 8'd0);

        // Bus released when not enabled; read_ack honoured regardless of output_en.
        output_en = 1'b0;
        @(negedge clk);
        chk("oe0_bus", bus0, 8'h00);
        chk("oe0_wait", {7'd0, wr0}, 8'd0);
        chk("oe0_dv", {7'd0, dv0}, 8'd1);
        ack_pulse();
        @(negedge clk);
        chk("oe0_ack_dv", {7'd0, dv0}, 8'd0);
        output_en = 1'b1;
        @(negedge clk);
        chk("oe1_wait", {7'd0, wr0}, 8'd1);

`ifdef INPUT_REGISTER_BCD_EN
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("bcd_rst_err", {7'd0, be0}, 8'd0);
        press("bcd_42", 8'h42, 1'b0, 1'b0, 1'b0);
        chk("bcd_42_bus", bus0, 8'd42);
        chk("bcd_42_err", {7'd0, be0}, 8'd0);
        ack_pulse();
        press("bcd_4c", 8'h4C, 1'b0, 1'b0, 1'b0);
        chk("bcd_4c_dv", {7'd0, dv0}, 8'd0);
        chk("bcd_4c_err", {7'd0, be0}, 8'd1);
        chk("bcd_4c_err_ow", {7'd0, be1}, 8'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
